// File: rtl/stopwatch_pkg.sv
// Shared types, constants and BCD helpers for the SS.hh stopwatch/timer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    MODE_UP0    = 2'b00,
    MODE_UPLOAD = 2'b01,
    MODE_DN99   = 2'b10,
    MODE_DNLOAD = 2'b11
  } mode_e;

  // d3 d2 . d1 d0 : tens of seconds, seconds, tenths, hundredths
  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd_time_t;

  localparam bcd_time_t TIME_ZERO = 16'h0000;
  localparam bcd_time_t TIME_MAX  = 16'h9999;

  // Active-low segment codes, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Preload digits above 9 are not valid BCD; saturate them to 9.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Value loaded into the counter while reset is held.
  function automatic bcd_time_t start_value(input mode_e m, input logic [3:0] l3,
                                            input logic [3:0] l2);
    bcd_time_t v;
    case (m)
      MODE_UP0:  v = TIME_ZERO;
      MODE_DN99: v = TIME_MAX;
      default: begin
        v.d3 = clamp_bcd(l3);
        v.d2 = clamp_bcd(l2);
        v.d1 = 4'd0;
        v.d0 = 4'd0;
      end
    endcase
    return v;
  endfunction

  // Add one hundredth with BCD carry ripple; 99.99 wraps to 00.00 (callers guard it).
  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.d0 != 4'd9) r.d0 = t.d0 + 4'd1;
    else begin
      r.d0 = 4'd0;
      if (t.d1 != 4'd9) r.d1 = t.d1 + 4'd1;
      else begin
        r.d1 = 4'd0;
        if (t.d2 != 4'd9) r.d2 = t.d2 + 4'd1;
        else begin
          r.d2 = 4'd0;
          r.d3 = (t.d3 != 4'd9) ? t.d3 + 4'd1 : 4'd0;
        end
      end
    end
    return r;
  endfunction

  // Subtract one hundredth with BCD borrow ripple; 00.00 wraps to 99.99 (callers guard it).
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.d0 != 4'd0) r.d0 = t.d0 - 4'd1;
    else begin
      r.d0 = 4'd9;
      if (t.d1 != 4'd0) r.d1 = t.d1 - 4'd1;
      else begin
        r.d1 = 4'd9;
        if (t.d2 != 4'd0) r.d2 = t.d2 - 4'd1;
        else begin
          r.d2 = 4'd9;
          r.d3 = (t.d3 != 4'd0) ? t.d3 - 4'd1 : 4'd9;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low 7-segment decoder; non-BCD input blanks the digit.
// Latency: purely combinational, 0 cycles.
// Backpressure: none.
module bcd_to_7seg
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one digit
  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/stopwatch_timer_main.sv
// SS.hh stopwatch / countdown timer driving a scanned active-low 4-digit display.
// Latency: button-to-run 1 cycle (3 with STW_BTN_SYNC_EN defined); first tick TICK_DIV cycles after run rises.
// Backpressure: none; display outputs free-run from registered state every cycle.
module stopwatch_timer_main
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV    = 1_000_000,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic       clk,
  input  logic       resetButton,
  input  logic       startStopButton,
  input  logic [1:0] mode,
  input  logic [3:0] dig3_load,
  input  logic [3:0] dig2_load,
  output logic [6:0] out_seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  logic            btn_q, btn_d;
  logic            run_q, run_d;
  logic            down_q;
  logic [PW-1:0]   pre_q, pre_d;
  bcd_time_t       cnt_q, cnt_d;
  logic [RW-1:0]   ref_q, ref_d;
  logic [1:0]      sel_q, sel_d;
  logic            btn_edge;
  logic            tick;
  logic            at_end;
  logic            next_at_end;
  logic [3:0]      digit;

`ifdef STW_BTN_SYNC_EN
  logic [1:0]      sync_q, sync_d;
`endif

  // Button conditioning: optional 2-flop synchronizer, then rising-edge detect
  always_comb begin
`ifdef STW_BTN_SYNC_EN
    sync_d = {sync_q[0], startStopButton};
    btn_d  = sync_q[1];
`else
    btn_d  = startStopButton;
`endif
    btn_edge = btn_d & ~btn_q;
  end

  // Prescaler, BCD counter and run flag next-state
  always_comb begin
    tick   = run_q && (pre_q == PRE_LAST);
    at_end = down_q ? (cnt_q == TIME_ZERO) : (cnt_q == TIME_MAX);

    // Prescaler freezes while stopped so a restart keeps the partial tick.
    pre_d = pre_q;
    if (run_q) pre_d = tick ? '0 : pre_q + PW'(1);

    cnt_d = cnt_q;
    if (tick && !at_end) cnt_d = down_q ? bcd_dec(cnt_q) : bcd_inc(cnt_q);

    // Reaching (or sitting at) the terminal value forces run low, which also
    // makes a start press at the terminal value a no-op.
    next_at_end = down_q ? (cnt_d == TIME_ZERO) : (cnt_d == TIME_MAX);
    run_d       = (run_q ^ btn_edge) & ~next_at_end;
  end

  // Display scan: digit select steps every REFRESH_DIV cycles
  always_comb begin
    ref_d = ref_q + RW'(1);
    sel_d = sel_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      sel_d = sel_q + 2'd1;
    end
  end

  // State registers; reset loads the start value and drops any same-cycle button edge
  always_ff @(posedge clk) begin
    btn_q <= btn_d;
`ifdef STW_BTN_SYNC_EN
    sync_q <= sync_d;
`endif
    if (resetButton) begin
      down_q <= mode[1];
      cnt_q  <= start_value(mode_e'(mode), dig3_load, dig2_load);
      run_q  <= 1'b0;
      pre_q  <= '0;
      ref_q  <= '0;
      sel_q  <= 2'd0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      pre_q  <= pre_d;
      ref_q  <= ref_d;
      sel_q  <= sel_d;
    end
  end

  // Output drive: pick the selected digit, light one anode, dp between d2 and d1
  always_comb begin
    case (sel_q)
      2'd0:    digit = cnt_q.d0;
      2'd1:    digit = cnt_q.d1;
      2'd2:    digit = cnt_q.d2;
      default: digit = cnt_q.d3;
    endcase
    an = ~(4'b0001 << sel_q);
    dp = (sel_q != 2'd2);
  end

  bcd_to_7seg u_seg (
    .bcd (digit),
    .seg (out_seg)
  );

endmodule

// File: tb/tb_stopwatch_timer_main.sv
// Directed bench for stopwatch_timer_main with TICK_DIV=2, REFRESH_DIV=1.
// Stimulus pushes expected time values into a scoreboard; a negedge monitor pops and compares.
// The monitor tracks the scan phase itself and derives the expected an/out_seg/dp/run.
module tb_stopwatch_timer_main;

  logic       clk = 1'b0;
  logic       resetButton;
  logic       startStopButton;
  logic [1:0] mode;
  logic [3:0] dig3_load;
  logic [3:0] dig2_load;
  logic [6:0] out_seg;
  logic [3:0] an;
  logic       dp;

  stopwatch_timer_main #(.TICK_DIV(2), .REFRESH_DIV(1)) dut (
    .clk             (clk),
    .resetButton     (resetButton),
    .startStopButton (startStopButton),
    .mode            (mode),
    .dig3_load       (dig3_load),
    .dig2_load       (dig2_load),
    .out_seg         (out_seg),
    .an              (an),
    .dp              (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          target;
    logic [15:0] val;
    logic        run;
    string       name;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  logic [1:0] ph  = 2'd0;
  int         n_checks = 0;
  int         n_pass   = 0;

  // Cycle count and the bench's own view of the scan position
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ph  <= resetButton ? 2'd0 : ph + 2'd1;
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [12:0] want_vec(input logic [1:0] p, input logic [15:0] v,
                                           input logic r);
    logic [3:0] d;
    logic [3:0] a;
    d = v[4*p +: 4];
    a = 4'b1111;
    a[p] = 1'b0;
    return {a, seg_of(d), (p == 2'd2) ? 1'b0 : 1'b1, r};
  endfunction

  exp_t        cur;
  logic [12:0] act_v;
  logic [12:0] want_v;

  // Monitor: compare every scoreboard entry due at this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].target <= cyc) begin
      cur = sb.pop_front();
      n_checks++;
      if (cur.target < cyc) begin
        $display("FAIL %s: sample slot %0d missed (now %0d)", cur.name, cur.target, cyc);
      end else begin
        act_v  = {an, out_seg, dp, dut.run_q};
        want_v = want_vec(ph, cur.val, cur.run);
        if (act_v === want_v) n_pass++;
        else
          $display("FAIL %s cyc=%0d an/seg/dp/run got %b/%h/%b/%b want %b/%h/%b/%b (value %h)",
                   cur.name, cyc, act_v[12:9], act_v[8:2], act_v[1], act_v[0],
                   want_v[12:9], want_v[8:2], want_v[1], want_v[0], cur.val);
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string nm, input int dly, input logic [15:0] v, input logic r);
    exp_t ent;
    ent.target = cyc + dly;
    ent.val    = v;
    ent.run    = r;
    ent.name   = nm;
    sb.push_back(ent);
  endtask

  // Frozen value: check all four scan positions over the next four cycles
  task automatic check_value(input string nm, input logic [15:0] v, input logic r);
    for (int k = 0; k < 4; k++) sb_push(nm, k, v, r);
    tick_n(4);
  endtask

  // One reset cycle; returns #1 after the reset edge
  task automatic do_reset(input logic [1:0] m, input logic [3:0] l3, input logic [3:0] l2,
                          input logic with_btn);
    @(posedge clk);
    #1;
    mode            = m;
    dig3_load       = l3;
    dig2_load       = l2;
    resetButton     = 1'b1;
    startStopButton = with_btn;
    @(posedge clk);
    #1;
    resetButton     = 1'b0;
    startStopButton = 1'b0;
  endtask

  // One-cycle button pulse; returns #1 after the edge that samples it
  task automatic press();
    startStopButton = 1'b1;
    @(posedge clk);
    #1;
    startStopButton = 1'b0;
  endtask

  initial begin
    resetButton     = 1'b1;
    startStopButton = 1'b0;
    mode            = 2'b00;
    dig3_load       = 4'd0;
    dig2_load       = 4'd0;
    tick_n(3);

    // Reset state in mode 00, then inputs changed without reset are ignored
    do_reset(2'b00, 4'd0, 4'd0, 1'b0);
    check_value("rst_up0", 16'h0000, 1'b0);
    mode = 2'b11; dig3_load = 4'd9; dig2_load = 4'd9;
    check_value("no_resample", 16'h0000, 1'b0);

    // Mode 00 counting with carry into tenths, then stop
    do_reset(2'b00, 4'd0, 4'd0, 1'b0);
    press();
    sb_push("up_t1",  3,  16'h0001, 1'b1);
    sb_push("up_t2",  4,  16'h0002, 1'b1);
    sb_push("up_t9",  19, 16'h0009, 1'b1);
    sb_push("up_t10", 20, 16'h0010, 1'b1);
    tick_n(20);
    press();
    check_value("up_stop", 16'h0010, 1'b0);

    // Stop after 3 ticks, resume keeps the partial prescaler count
    do_reset(2'b00, 4'd0, 4'd0, 1'b0);
    press();
    tick_n(6);
    press();
    check_value("freeze", 16'h0003, 1'b0);
    tick_n(2);
    press();
    sb_push("resume_run", 0, 16'h0003, 1'b1);
    sb_push("resume_t4",  1, 16'h0004, 1'b1);
    sb_push("resume_t4b", 2, 16'h0004, 1'b1);
    tick_n(3);

    // Reset with a simultaneous start edge mid-count; load 12 clamps to 9
    do_reset(2'b01, 4'd12, 4'd3, 1'b1);
    check_value("rst_btn", 16'h9300, 1'b0);
    check_value("rst_btn_hold", 16'h9300, 1'b0);

    // Mode 10 start value
    do_reset(2'b10, 4'd0, 4'd0, 1'b0);
    check_value("rst_dn99", 16'h9999, 1'b0);

    // Mode 11 from 01.00 down to 00.00, hold, start press ignored
    do_reset(2'b11, 4'd0, 4'd1, 1'b0);
    press();
    sb_push("dn_t1",   3,   16'h0099, 1'b1);
    sb_push("dn_t2",   4,   16'h0098, 1'b1);
    sb_push("dn_t99",  199, 16'h0001, 1'b1);
    sb_push("dn_zero", 200, 16'h0000, 1'b0);
    tick_n(200);
    tick_n(10);
    check_value("dn_hold", 16'h0000, 1'b0);
    press();
    check_value("dn_press", 16'h0000, 1'b0);

    // Mode 01 from 99.00 up to saturation at 99.99
    do_reset(2'b01, 4'd9, 4'd9, 1'b0);
    press();
    sb_push("upl_t1",  3,   16'h9901, 1'b1);
    sb_push("upl_t10", 20,  16'h9910, 1'b1);
    sb_push("upl_t97", 195, 16'h9997, 1'b1);
    sb_push("upl_sat", 199, 16'h9999, 1'b0);
    tick_n(199);
    tick_n(5);
    check_value("upl_hold", 16'h9999, 1'b0);
    press();
    check_value("upl_press", 16'h9999, 1'b0);

    tick_n(2);
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      n_checks++;
      $display("FAIL %s: never sampled (slot %0d)", cur.name, cur.target);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_timer_main.md
# stopwatch_timer_main

Four-digit BCD stopwatch/countdown timer for a 7-segment display board, showing seconds and hundredths as SS.hh. It sits at the top of the board design. It takes a start/stop button, a reset button, a 2-bit mode select and two BCD preload digits, and drives a time-multiplexed, active-low 4-digit display.

## Interface
- `TICK_DIV`, default 1_000_000: clock cycles per 0.01 s count tick; legal range ≥1.
- `REFRESH_DIV`, default 100_000: clock cycles each digit stays lit during display scan; legal range ≥1.
- `clk`  in  1  system clock. One clock domain.
- `resetButton`  in  1  reset; synchronous, active-high.
- `startStopButton`  in  1  run/stop toggle, acted on at its rising edge.
- `mode`  in  2  00 count up from 00.00; 01 count up from load; 10 count down from 99.99; 11 count down from load.
- `dig3_load`  in  4  BCD tens-of-seconds preload.
- `dig2_load`  in  4  BCD units-of-seconds preload.
- `out_seg`  out  7  segments, active-low; bit0=a … bit6=g.
- `an`  out  4  digit anodes, active-low; an[3] is the leftmost digit.
- `dp`  out  1  decimal point, active-low.

## Operation
- The time value is four BCD digits d3 d2 . d1 d0: tens of seconds, units of seconds, tenths, hundredths.
- Reset loads the start value and clears `run`, the prescaler and the scan counter.
  - Start value is 00.00 for mode 00 and 99.99 for mode 10.
  - For modes 01 and 11 it is {dig3_load, dig2_load}.00.
  - A load digit >9 is clamped to 9.
- `mode` and the load inputs are sampled only at reset. Changing them without a reset has no effect on the count.
- Each rising edge of `startStopButton` toggles `run`.
- While `run`=1, the prescaler counts 0..TICK_DIV-1. It emits a one-cycle tick on the TICK_DIV-1 → 0 wrap.
- While `run`=0, the prescaler holds its value. A stop/restart therefore does not lose a partial tick.
- Up modes: each tick adds 1 with BCD carries d0→d1→d2→d3, each digit wrapping 9→0.
  - At 99.99 the count holds and `run` is cleared.
- Down modes: each tick subtracts 1 with BCD borrow, each digit wrapping 0→9.
  - At 00.00 the count holds and `run` is cleared.
  - A down mode that starts at 00.00 never moves; pressing start leaves `run` at 0.
- Reset and a button edge in the same cycle: reset wins, and the edge is discarded.
- Display: a 2-bit digit select advances every REFRESH_DIV cycles, in the order 0,1,2,3,0…
  - Exactly one `an` bit is low: an[i] selects digit di.
  - `out_seg` carries the 7-segment code of the selected digit: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - `dp` is 0 only while digit 2 is selected; otherwise it is 1.

## Timing
- All state is updated on the posedge of `clk`.
- Output values during and after reset:
  - `an`=4'b1110 (digit 0);
  - `out_seg` is the code for the start value's d0;
  - `dp`=1;
  - `run`=0.
- Button-edge latency: the button is registered once (`btn_q`), and edge = button & ~btn_q. `run` toggles at the same clock edge that samples the edge. `run` is visible 1 cycle after the button rises.
- The first tick occurs TICK_DIV cycles after `run` rises. The count changes on the same edge that the tick is generated, i.e. the count is registered.
- Outputs are combinational from registered digit select and count. There are no extra pipeline stages.
- The display scan runs continuously regardless of `run`.

## Configuration
- `STW_BTN_SYNC_EN`: when defined, `startStopButton` first passes through a 2-flop synchronizer, ahead of the edge register. Button-to-`run` latency becomes 3 cycles.
- When `STW_BTN_SYNC_EN` is undefined there is no synchronizer, and latency is 1 cycle.

## Structure
- Package `stopwatch_pkg` holds:
  - the mode encodings (MODE_UP0, MODE_UPLOAD, MODE_DN99, MODE_DNLOAD);
  - the 7-segment code constants;
  - the start constants 00.00 and 99.99.
- One sub-module `bcd_to_7seg`: 4-bit BCD in, active-low 7-bit segments out, combinational. Input values >9 give all segments off (7'h7F).
- The counter, prescaler, button logic and scan logic live in the top module.

## Test plan
All scenarios use TICK_DIV=2 and REFRESH_DIV=1, with the `STW_BTN_SYNC_EN` macro undefined.
- Mode 00: reset, then pulse start for 1 cycle. After 2 ticks (≈5 cycles) d0=2, and `an`=1110 shows 7'h24. Wraps to 00.10 after 10 ticks.
- Mode 11 with dig3=0, dig2=1: reset, start. After 100 ticks the display reads 00.00. Count holds, `run`=0, and further cycles do not change it.
- Mode 01 with dig3=9, dig2=9: start. After 99 ticks the count saturates at 99.99 and `run` clears.
- Start, then a second press after 3 ticks: the count freezes at 00.03. A third press resumes counting from 00.03.
- Scan check: over 4 consecutive cycles `an` cycles 1110, 1101, 1011, 0111, and `dp`=0 only while `an`=1011.
- Reset asserted mid-count together with a start edge: the next cycle shows the start value with `run`=0. dig3_load=12 in mode 01 loads 9.
